// File: rtl/spi_slave_tx_stream_if.sv
// spi_slave_tx_stream_if: AXI4-Stream word feed into the SPI slave transmitter.
interface spi_slave_tx_stream_if #(parameter int DATA_W = 8) ();
    logic [DATA_W-1:0] axis_rdata;
    logic              axis_rvalid;
    logic              axis_rready;
    logic              axis_rlast;
    modport master (output axis_rdata, axis_rvalid, axis_rlast, input axis_rready);
    modport slave  (input axis_rdata, axis_rvalid, axis_rlast, output axis_rready);
endinterface

// File: rtl/spi_slave_tx_stream.sv
// spi_slave_tx_stream: AXI4-Stream to SPI-slave MISO transmitter with word FIFO, oversampled in axi_aclk.
// Optional SPI_TX_UNDERRUN_CNT_EN adds a saturating 16-bit underrun counter output.
module spi_slave_tx_stream #(
    parameter int              DATA_W     = 8,
    parameter int              FIFO_DEPTH = 16,
    parameter bit              CPOL       = 1'b0,
    parameter bit              CPHA       = 1'b0,
    parameter bit              MSB_FIRST  = 1'b1,
    parameter logic [DATA_W-1:0] IDLE_WORD = '1
) (
    input  logic                          axi_aclk,
    input  logic                          axi_areset,
    input  logic                          spi_clk,
    input  logic                          spi_cs,
    output logic                          spi_miso,
    output logic                          spi_miso_oe,
    spi_slave_tx_stream_if.slave          axis,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          frame_done,
    output logic                          underrun
`ifdef SPI_TX_UNDERRUN_CNT_EN
    ,
    output logic [15:0]                   underrun_cnt
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    state_t            state, nxt;
    logic [2:0]        sclk_q, cs_q;
    logic [DATA_W:0]   mem [FIFO_DEPTH];
    logic [AW:0]       wp, rp;
    logic [DATA_W-1:0] sh, word;
    logic [DATA_W:0]   head;
    logic [CW-1:0]     cnt;
    logic              cur_last, pend, push, pop, empty, full, done;
    logic              lead, trail, cs_fall, cs_rise, rise_s, fall_s;

    function automatic logic hd(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? w[DATA_W-1] : w[0];
    endfunction

    function automatic logic [DATA_W-1:0] shf(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? {w[DATA_W-2:0], 1'b1} : {1'b1, w[DATA_W-1:1]};
    endfunction

    // cs chain resets low so a cs already low at reset release is not seen as a fall
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            sclk_q <= {3{CPOL}};
            cs_q   <= '0;
        end else begin
            sclk_q <= {sclk_q[1:0], spi_clk};
            cs_q   <= {cs_q[1:0], spi_cs};
        end
    end

    assign rise_s  = sclk_q[1] & ~sclk_q[2];
    assign fall_s  = ~sclk_q[1] & sclk_q[2];
    assign lead    = CPOL ? fall_s : rise_s;
    assign trail   = CPOL ? rise_s : fall_s;
    assign cs_fall = ~cs_q[1] & cs_q[2];
    assign cs_rise = cs_q[1] & ~cs_q[2];

    assign fifo_level  = wp - rp;
    assign empty       = wp == rp;
    assign full        = fifo_level == (AW+1)'(FIFO_DEPTH);
    assign head        = mem[rp[AW-1:0]];
    assign word        = (empty || pend) ? IDLE_WORD : head[DATA_W-1:0];
    assign push        = axis.axis_rvalid & axis.axis_rready;
    assign axis.axis_rready = ~axi_areset & (~full | pop);
    assign spi_miso_oe = state != IDLE;

    always_ff @(posedge axi_aclk) begin
        if (push) mem[wp[AW-1:0]] <= {axis.axis_rlast, axis.axis_rdata};
    end

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) state <= IDLE;
        else            state <= nxt;
    end

    always_comb begin
        pop  = state == LOAD && !empty && !pend;
        done = state == SHIFT && trail && cnt == CW'(DATA_W-1) && !cs_rise;
        nxt  = cs_rise ? IDLE :
               state == IDLE ? (cs_fall ? LOAD : IDLE) :
               state == LOAD ? SHIFT :
               done ? LOAD : SHIFT;
    end

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            wp         <= '0;
            rp         <= '0;
            sh         <= IDLE_WORD;
            cnt        <= '0;
            cur_last   <= 1'b0;
            pend       <= 1'b0;
            spi_miso   <= hd(IDLE_WORD);
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            wp         <= wp + (AW+1)'(push);
            rp         <= rp + (AW+1)'(pop);
            frame_done <= done & cur_last;
            underrun   <= state == LOAD && empty && !pend;
            if (cs_rise) begin
                cnt  <= '0;
                pend <= 1'b0;
            end else if (state == LOAD) begin
                sh       <= CPHA ? word : shf(word);
                cur_last <= pop & head[DATA_W];
                cnt      <= '0;
                if (!CPHA) spi_miso <= hd(word);
            end else if (state == SHIFT) begin
                if (trail) begin
                    cnt <= cnt + 1'b1;
                    if (done) begin
                        pend <= pend | cur_last;
                    end else if (!CPHA) begin
                        spi_miso <= hd(sh);
                        sh       <= shf(sh);
                    end
                end
                if (lead && CPHA) begin
                    spi_miso <= hd(sh);
                    sh       <= shf(sh);
                end
            end
        end
    end

`ifdef SPI_TX_UNDERRUN_CNT_EN
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset)                      underrun_cnt <= '0;
        else if (underrun && ~&underrun_cnt) underrun_cnt <= underrun_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_spi_slave_tx_stream.sv
// tb_spi_slave_tx_stream: directed checks of a mode-0 MSB-first and a mode-3 LSB-first instance.
module tb_spi_slave_tx_stream;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       sclk0, cs0, miso0, oe0, fd0p, ur0p;
    logic       sclk3, cs3, miso3, oe3, fd3p, ur3p;
    logic [4:0] lvl0, lvl3;
`ifdef SPI_TX_UNDERRUN_CNT_EN
    logic [15:0] uc0, uc3;
`endif
    int pass_n = 0, total_n = 0;
    int fd0 = 0, ur0 = 0, fd3 = 0, ur3 = 0;

    spi_slave_tx_stream_if #(.DATA_W(8)) ax0 ();
    spi_slave_tx_stream_if #(.DATA_W(8)) ax3 ();

    spi_slave_tx_stream u0 (
        .axi_aclk(clk), .axi_areset(rst), .spi_clk(sclk0), .spi_cs(cs0),
        .spi_miso(miso0), .spi_miso_oe(oe0), .axis(ax0), .fifo_level(lvl0),
        .frame_done(fd0p), .underrun(ur0p)
`ifdef SPI_TX_UNDERRUN_CNT_EN
        , .underrun_cnt(uc0)
`endif
    );

    spi_slave_tx_stream #(.CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0)) u3 (
        .axi_aclk(clk), .axi_areset(rst), .spi_clk(sclk3), .spi_cs(cs3),
        .spi_miso(miso3), .spi_miso_oe(oe3), .axis(ax3), .fifo_level(lvl3),
        .frame_done(fd3p), .underrun(ur3p)
`ifdef SPI_TX_UNDERRUN_CNT_EN
        , .underrun_cnt(uc3)
`endif
    );

    always @(negedge clk) begin
        if (fd0p) fd0++;
        if (ur0p) ur0++;
        if (fd3p) fd3++;
        if (ur3p) ur3++;
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; cs0 = 1'b1; cs3 = 1'b1; sclk0 = 1'b0; sclk3 = 1'b1;
        ax0.axis_rvalid = 1'b0; ax3.axis_rvalid = 1'b0;
        wait_n(3);
        rst = 1'b0;
        wait_n(4);
    endtask

    task automatic push0(input logic [7:0] d, input logic l);
        @(negedge clk);
        ax0.axis_rdata = d; ax0.axis_rlast = l; ax0.axis_rvalid = 1'b1;
        @(negedge clk);
        ax0.axis_rvalid = 1'b0;
    endtask

    task automatic push3(input logic [7:0] d, input logic l);
        @(negedge clk);
        ax3.axis_rdata = d; ax3.axis_rlast = l; ax3.axis_rvalid = 1'b1;
        @(negedge clk);
        ax3.axis_rvalid = 1'b0;
    endtask

    // mode 0: sample at rising (leading) edge, MSB-first assembly
    task automatic xfer0(input int n, output logic [31:0] rx);
        rx = '0;
        for (int i = 0; i < n; i++) begin
            rx = {rx[30:0], miso0};
            sclk0 = 1'b1; wait_n(8);
            sclk0 = 1'b0; wait_n(8);
        end
    endtask

    // mode 3: DUT drives on falling edge, sample on rising edge, LSB-first assembly
    task automatic xfer3(input int n, output logic [31:0] rx);
        rx = '0;
        for (int i = 0; i < n; i++) begin
            sclk3 = 1'b0; wait_n(8);
            rx[i] = miso3;
            sclk3 = 1'b1; wait_n(8);
        end
    endtask

    task automatic test_reset();
        ax0.axis_rdata = '0; ax0.axis_rlast = 1'b0; ax0.axis_rvalid = 1'b0;
        ax3.axis_rdata = '0; ax3.axis_rlast = 1'b0; ax3.axis_rvalid = 1'b0;
        cs0 = 1'b1; cs3 = 1'b1; sclk0 = 1'b0; sclk3 = 1'b1;
        rst = 1'b1;
        wait_n(3);
        total_n++; if (ax0.axis_rready !== 1'b0) $display("FAIL rst_rready0: got %b want 0", ax0.axis_rready); else pass_n++;
        total_n++; if (ax3.axis_rready !== 1'b0) $display("FAIL rst_rready3: got %b want 0", ax3.axis_rready); else pass_n++;
        total_n++; if (oe0 !== 1'b0) $display("FAIL rst_oe0: got %b want 0", oe0); else pass_n++;
        total_n++; if (oe3 !== 1'b0) $display("FAIL rst_oe3: got %b want 0", oe3); else pass_n++;
        total_n++; if (miso0 !== 1'b1) $display("FAIL rst_miso0: got %b want 1", miso0); else pass_n++;
        total_n++; if (miso3 !== 1'b1) $display("FAIL rst_miso3: got %b want 1", miso3); else pass_n++;
        total_n++; if (lvl0 !== 5'd0) $display("FAIL rst_level0: got %0d want 0", lvl0); else pass_n++;
        total_n++; if (lvl3 !== 5'd0) $display("FAIL rst_level3: got %0d want 0", lvl3); else pass_n++;
        total_n++; if ({fd0p, ur0p, fd3p, ur3p} !== 4'b0) $display("FAIL rst_pulses: got %b want 0000", {fd0p, ur0p, fd3p, ur3p}); else pass_n++;
        rst = 1'b0;
        #1;
        total_n++; if (ax0.axis_rready !== 1'b1) $display("FAIL rel_rready0: got %b want 1", ax0.axis_rready); else pass_n++;
        total_n++; if (ax3.axis_rready !== 1'b1) $display("FAIL rel_rready3: got %b want 1", ax3.axis_rready); else pass_n++;
        wait_n(4);
    endtask

    task automatic test_mode0();
        logic [31:0] rx;
        int f, u;
        do_reset();
        push0(8'hA5, 1'b1);
        wait_n(1);
        total_n++; if (lvl0 !== 5'd1) $display("FAIL m0_level: got %0d want 1", lvl0); else pass_n++;
        f = fd0; u = ur0;
        cs0 = 1'b0; wait_n(8);
        total_n++; if (oe0 !== 1'b1) $display("FAIL m0_oe: got %b want 1", oe0); else pass_n++;
        xfer0(8, rx);
        total_n++; if (rx[7:0] !== 8'hA5) $display("FAIL m0_data: got %h want a5", rx[7:0]); else pass_n++;
        total_n++; if (fd0 - f !== 1) $display("FAIL m0_frame_done: got %0d want 1", fd0 - f); else pass_n++;
        total_n++; if (ur0 - u !== 0) $display("FAIL m0_underrun: got %0d want 0", ur0 - u); else pass_n++;
        cs0 = 1'b1; wait_n(8);
        total_n++; if (oe0 !== 1'b0) $display("FAIL m0_oe_off: got %b want 0", oe0); else pass_n++;
    endtask

    task automatic test_mode3();
        logic [31:0] rx;
        int f, u;
        do_reset();
        push3(8'h3C, 1'b0);
        push3(8'hC3, 1'b0);
        push3(8'h1E, 1'b1);
        f = fd3; u = ur3;
        cs3 = 1'b0; wait_n(8);
        xfer3(24, rx);
        total_n++; if (rx[23:0] !== 24'h1EC33C) $display("FAIL m3_data: got %h want 1ec33c", rx[23:0]); else pass_n++;
        total_n++; if (fd3 - f !== 1) $display("FAIL m3_frame_done: got %0d want 1", fd3 - f); else pass_n++;
        total_n++; if (ur3 - u !== 0) $display("FAIL m3_underrun: got %0d want 0", ur3 - u); else pass_n++;
        cs3 = 1'b1; wait_n(8);
    endtask

    task automatic test_underrun();
        logic [31:0] rx;
        int u;
        do_reset();
        u = ur0;
        cs0 = 1'b0; wait_n(8);
        xfer0(7, rx);
        rx = {rx[30:0], miso0};
        sclk0 = 1'b1; wait_n(8);
        total_n++; if (ur0 - u !== 1) $display("FAIL ur_pulse: got %0d want 1", ur0 - u); else pass_n++;
        sclk0 = 1'b0; wait_n(8);
        total_n++; if (rx[7:0] !== 8'hFF) $display("FAIL ur_data: got %h want ff", rx[7:0]); else pass_n++;
`ifdef SPI_TX_UNDERRUN_CNT_EN
        // second pulse comes from the reload after the eighth bit, FIFO still empty
        total_n++; if (uc0 !== 16'd2) $display("FAIL ur_cnt: got %0d want 2", uc0); else pass_n++;
`endif
        cs0 = 1'b1; wait_n(8);
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 16; i++) push0(8'h10 + 8'(i), 1'b0);
        total_n++; if (lvl0 !== 5'd16) $display("FAIL full_level: got %0d want 16", lvl0); else pass_n++;
        total_n++; if (ax0.axis_rready !== 1'b0) $display("FAIL full_rready: got %b want 0", ax0.axis_rready); else pass_n++;
        ax0.axis_rdata = 8'h99; ax0.axis_rlast = 1'b0; ax0.axis_rvalid = 1'b1;
        cs0 = 1'b0;
        wait_n(12);
        ax0.axis_rvalid = 1'b0;
        total_n++; if (lvl0 !== 5'd16) $display("FAIL full_pop_push: got %0d want 16", lvl0); else pass_n++;
        cs0 = 1'b1; wait_n(8);
    endtask

    task automatic test_cs_abort();
        logic [31:0] rx;
        int f;
        do_reset();
        push0(8'h0F, 1'b1);
        push0(8'h96, 1'b0);
        f = fd0;
        cs0 = 1'b0; wait_n(8);
        xfer0(3, rx);
        cs0 = 1'b1; wait_n(8);
        total_n++; if (rx[2:0] !== 3'b000) $display("FAIL ab_bits: got %b want 000", rx[2:0]); else pass_n++;
        total_n++; if (oe0 !== 1'b0) $display("FAIL ab_oe: got %b want 0", oe0); else pass_n++;
        total_n++; if (fd0 - f !== 0) $display("FAIL ab_frame_done: got %0d want 0", fd0 - f); else pass_n++;
        cs0 = 1'b0; wait_n(8);
        xfer0(8, rx);
        total_n++; if (rx[7:0] !== 8'h96) $display("FAIL ab_next: got %h want 96", rx[7:0]); else pass_n++;
        total_n++; if (lvl0 !== 5'd0) $display("FAIL ab_level: got %0d want 0", lvl0); else pass_n++;
        cs0 = 1'b1; wait_n(8);
    endtask

    task automatic test_packet_end();
        logic [31:0] rx;
        int f, u;
        do_reset();
        push0(8'hA1, 1'b1);
        push0(8'h55, 1'b0);
        f = fd0; u = ur0;
        cs0 = 1'b0; wait_n(8);
        xfer0(16, rx);
        total_n++; if (rx[15:0] !== 16'hA1FF) $display("FAIL pe_data: got %h want a1ff", rx[15:0]); else pass_n++;
        total_n++; if (ur0 - u !== 0) $display("FAIL pe_underrun: got %0d want 0", ur0 - u); else pass_n++;
        total_n++; if (fd0 - f !== 1) $display("FAIL pe_frame_done: got %0d want 1", fd0 - f); else pass_n++;
        total_n++; if (lvl0 !== 5'd1) $display("FAIL pe_level: got %0d want 1", lvl0); else pass_n++;
        cs0 = 1'b1; wait_n(8);
        cs0 = 1'b0; wait_n(8);
        xfer0(8, rx);
        total_n++; if (rx[7:0] !== 8'h55) $display("FAIL pe_next: got %h want 55", rx[7:0]); else pass_n++;
        cs0 = 1'b1; wait_n(8);
    endtask

    task automatic test_cs_in_reset();
        @(negedge clk);
        rst = 1'b1; cs0 = 1'b0;
        wait_n(3);
        rst = 1'b0;
        wait_n(12);
        total_n++; if (oe0 !== 1'b0) $display("FAIL csr_ignored: got %b want 0", oe0); else pass_n++;
        cs0 = 1'b1; wait_n(8);
        cs0 = 1'b0; wait_n(8);
        total_n++; if (oe0 !== 1'b1) $display("FAIL csr_new_fall: got %b want 1", oe0); else pass_n++;
        cs0 = 1'b1; wait_n(8);
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_mode3();
        test_underrun();
        test_full();
        test_cs_abort();
        test_packet_end();
        test_cs_in_reset();
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
